sjram_arbiter: RTL and testbench

Three-way access arbiter for one single-port 2K×8 work/video RAM (1-cycle registered read, `cen`-qualified, active-low write strobe). It shares the RAM between a CPU requester, a video fetch requester and an internal fill engine. With this block in place the board does not need a true dual-port RAM for the CPU/video shared buffers. It sits between the CPU bus decode, the tile/sprite fetch logic and the RAM instance.

---
 rtl/sjram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sjram_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sjram_arbiter.sv
// sjram_arbiter: shares one single-port work RAM
// between CPU, video fetch and a fill engine.
module sjram_arbiter #(
  parameter int              AW          = 11,
  parameter int              DW          = 8,
  parameter logic [DW-1:0]   CLR_VALUE   = 8'h00,
  parameter int              CPU_MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_dout,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_cen,
  output logic          ram_nWE,
  input  logic [DW-1:0] ram_q
);

  localparam int WW = $clog2(CPU_MAXWAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    VID_RD,
    CPU_WR
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          vid_ack_q, vid_ack_d;
  logic [DW-1:0] vid_dout_q, vid_dout_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic          ram_cen_q, ram_cen_d;
  logic          ram_nwe_q, ram_nwe_d;
  logic          cpu_first;

  // CPU overrides video once it has been bypassed too often
  assign cpu_first = cpu_req
                   && (wait_q >= WW'(CPU_MAXWAIT));

  // Arbitration, access sequencing and fill engine
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    clr_addr_d = clr_addr_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    cpu_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    vid_ack_d  = 1'b0;
    vid_dout_d = vid_dout_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_cen_d  = 1'b0;
    ram_nwe_d  = 1'b1;

    if (!cpu_req) wait_d = '0;

    if (clr_start && !clr_busy_q) begin
      clr_busy_d = 1'b1;
      clr_addr_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (vid_req && !cpu_first) begin
          ram_addr_d = vid_addr;
          ram_cen_d  = 1'b1;
          state_d    = VID_RD;
          if (cpu_req) wait_d = wait_q + 1'b1;
        end else if (cpu_req) begin
          ram_addr_d = cpu_addr;
          ram_cen_d  = 1'b1;
          wait_d     = '0;
          if (cpu_we) begin
            ram_data_d = cpu_din;
            ram_nwe_d  = 1'b0;
            state_d    = CPU_WR;
          end else begin
            state_d    = CPU_RD;
          end
        end else if (clr_busy_q) begin
          ram_addr_d = clr_addr_q;
          ram_data_d = CLR_VALUE;
          ram_cen_d  = 1'b1;
          ram_nwe_d  = 1'b0;
          clr_addr_d = clr_addr_q + 1'b1;
          if (&clr_addr_q) begin
            clr_busy_d = 1'b0;
            clr_done_d = 1'b1;
          end
        end
      end
      CPU_RD: begin
        cpu_dout_d = ram_q;
        cpu_ack_d  = 1'b1;
        state_d    = IDLE;
      end
      VID_RD: begin
        vid_dout_d = ram_q;
        vid_ack_d  = 1'b1;
        state_d    = IDLE;
      end
      CPU_WR: begin
        cpu_ack_d  = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // State and registered RAM/requester outputs
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      clr_addr_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      vid_ack_q  <= 1'b0;
      vid_dout_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_cen_q  <= 1'b0;
      ram_nwe_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      clr_addr_q <= clr_addr_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_dout_q <= cpu_dout_d;
      vid_ack_q  <= vid_ack_d;
      vid_dout_q <= vid_dout_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_cen_q  <= ram_cen_d;
      ram_nwe_q  <= ram_nwe_d;
    end
  end

  assign cpu_ack  = cpu_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign vid_ack  = vid_ack_q;
  assign vid_dout = vid_dout_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_cen  = ram_cen_q;
  assign ram_nWE  = ram_nwe_q;

endmodule

// File: tb/tb_sjram_arbiter.sv
// tb_sjram_arbiter: vector table plus request
// scoreboard for the shared-RAM arbiter.
`timescale 1ns/1ps
module tb_sjram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } op_t;

  logic          clk = 1'b0;
  logic          nRESET;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_ack;
  logic [DW-1:0] cpu_dout;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_dout;
  logic          clr_start, clr_busy, clr_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_cen, ram_nWE;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] shadow [N];
  logic          preload = 1'b0;

  int checks, errors, tick_no;
  int cpu_issue_t, done_cnt;
  bit rand_gap, chk_lat;
  op_t cpu_ops[$], vid_ops[$];
  op_t cpu_sb[$], vid_sb[$];
  byte ack_log[$];
  op_t tab[9];

  sjram_arbiter dut (
    .clk(clk), .nRESET(nRESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_ack(vid_ack), .vid_dout(vid_dout),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cen(ram_cen), .ram_nWE(ram_nWE),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // RAM: posedge write, read data follows the
  // registered address presented by the arbiter
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) mem[i] <= 8'hFF;
    end else if (ram_cen && !ram_nWE) begin
      mem[ram_addr] <= ram_data;
    end
  end
  assign ram_q = ram_cen ? mem[ram_addr] : 8'hEE;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  // One clock: sample, score acks, drive requesters
  task automatic tick();
    op_t o;
    @(posedge clk);
    #1;
    tick_no++;
    if (clr_done) done_cnt++;
    if (cpu_ack) begin
      ack_log.push_back("C");
      if (cpu_sb.size() == 0) begin
        check("cpu_ack_unexpected", cpu_ack, 0);
      end else begin
        o = cpu_sb.pop_front();
        if (!o.we) check("cpu_dout", cpu_dout, o.exp);
        if (chk_lat)
          check("cpu_ack_latency",
                tick_no - cpu_issue_t, 2);
      end
      cpu_req = 1'b0;
    end
    if (vid_ack) begin
      ack_log.push_back("V");
      if (vid_sb.size() == 0) begin
        check("vid_ack_unexpected", vid_ack, 0);
      end else begin
        o = vid_sb.pop_front();
        check("vid_dout", vid_dout, o.exp);
      end
      vid_req = 1'b0;
    end
    if (!cpu_req && cpu_ops.size() != 0 &&
        (!rand_gap || $urandom_range(0, 1) == 0)) begin
      o = cpu_ops.pop_front();
      cpu_we   = o.we;
      cpu_addr = o.addr;
      cpu_din  = o.din;
      cpu_req  = 1'b1;
      cpu_sb.push_back(o);
      cpu_issue_t = tick_no;
    end
    if (!vid_req && vid_ops.size() != 0 &&
        (!rand_gap || $urandom_range(0, 1) == 0)) begin
      o = vid_ops.pop_front();
      vid_addr = o.addr;
      vid_req  = 1'b1;
      vid_sb.push_back(o);
    end
  endtask

  function automatic int pending();
    return cpu_ops.size() + vid_ops.size()
         + cpu_sb.size() + vid_sb.size();
  endfunction

  task automatic drain(input string name,
                       input int limit);
    int n;
    n = 0;
    while (pending() != 0 && n < limit) begin
      tick();
      n++;
    end
    check(name, pending(), 0);
    cpu_ops.delete(); vid_ops.delete();
    cpu_sb.delete(); vid_sb.delete();
    tick();
  endtask

  task automatic do_preload();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int i = 0; i < N; i++) shadow[i] = 8'hFF;
  endtask

  function automatic op_t mk(input logic we,
                             input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.din = d;
    if (we) shadow[a] = d;
    o.exp = we ? 8'h00 : shadow[a];
    return o;
  endfunction

  initial begin
    string seq;
    int wr, bad, dn, done_at, nz, n, d0, wc;
    checks = 0; errors = 0; tick_no = 0;
    done_cnt = 0; rand_gap = 0; chk_lat = 0;

    // Reset with every request asserted
    nRESET = 1'b0; preload = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 11'h020; cpu_din = 8'h00;
    vid_req = 1'b1; vid_addr = 11'h010;
    clr_start = 1'b1;
    for (int i = 0; i < N; i++) shadow[i] = 8'hFF;
    repeat (3) tick();
    preload = 1'b0;
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_vid_ack", vid_ack, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_vid_dout", vid_dout, 0);
    check("rst_ram_cen", ram_cen, 0);
    check("rst_ram_nWE", ram_nWE, 1);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    cpu_sb.push_back('{1'b0, 11'h020, 8'h00, 8'hFF});
    vid_sb.push_back('{1'b0, 11'h010, 8'h00, 8'hFF});
    nRESET = 1'b1;
    clr_start = 1'b0;
    tick();
    check("first_grant",
          {ram_cen, ram_nWE, ram_addr},
          {1'b1, 1'b1, 11'h010});
    drain("rst_release_drain", 20);

    // CPU vectors: write/read pairs and edges
    tab[0] = mk(1'b1, 11'h123, 8'hA5);
    tab[1] = mk(1'b0, 11'h123, 8'h00);
    tab[2] = mk(1'b1, 11'h000, 8'h3C);
    tab[3] = mk(1'b1, 11'h7FF, 8'hC3);
    tab[4] = mk(1'b0, 11'h7FF, 8'h00);
    tab[5] = mk(1'b0, 11'h000, 8'h00);
    tab[6] = mk(1'b1, 11'h123, 8'h5A);
    tab[7] = mk(1'b0, 11'h123, 8'h00);
    tab[8] = mk(1'b0, 11'h055, 8'h00);
    chk_lat = 1;
    for (int i = 0; i < 9; i++) begin
      cpu_ops.push_back(tab[i]);
      tick();
      tick();
      check($sformatf("grant_pins[%0d]", i),
            {ram_cen, ram_nWE, ram_addr},
            {1'b1, ~tab[i].we, tab[i].addr});
      if (tab[i].we)
        check($sformatf("grant_data[%0d]", i),
              ram_data, tab[i].din);
      drain($sformatf("vec_drain[%0d]", i), 10);
    end
    chk_lat = 0;

    // Starvation: video saturates, CPU forced in
    ack_log.delete();
    for (int i = 0; i < 8; i++)
      vid_ops.push_back(mk(1'b0, AW'(11'h120 + i), 8'h00));
    cpu_ops.push_back(mk(1'b0, 11'h7FF, 8'h00));
    cpu_ops.push_back(mk(1'b0, 11'h000, 8'h00));
    drain("starve_drain", 100);
    seq = "VVVVCVVVVC";
    check("starve_len", ack_log.size(), 10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      check($sformatf("starve_order[%0d]", i),
            ack_log[i], seq[i]);

    // Reset during a CPU read
    cpu_we = 1'b0; cpu_addr = 11'h123; cpu_req = 1'b1;
    tick();
    check("rd_grant_before_rst", ram_cen, 1);
    #2 nRESET = 1'b0;
    #1;
    check("rst_rd_cen", ram_cen, 0);
    check("rst_rd_nWE", ram_nWE, 1);
    cpu_req = 1'b0;
    tick();
    check("rst_rd_no_ack", cpu_ack, 0);
    nRESET = 1'b1;
    repeat (4) tick();

    // Reset in the middle of a fill
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (50) tick();
    check("fill_running", clr_busy, 1);
    #2 nRESET = 1'b0;
    #1;
    check("rst_fill_busy", clr_busy, 0);
    check("rst_fill_cen", {ram_cen, ram_nWE}, 2'b01);
    tick();
    nRESET = 1'b1;
    d0 = done_cnt; wc = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (ram_cen) wc++;
    end
    check("rst_fill_no_writes", wc, 0);
    check("rst_fill_no_done", done_cnt - d0, 0);

    // Full fill, no traffic, restart pulse ignored
    do_preload();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr = 0; bad = 0; dn = 0; done_at = -1;
    for (int t = 0; t < 2060; t++) begin
      clr_start = (t == 100);
      tick();
      if (t == 10) check("fill_busy", clr_busy, 1);
      if (ram_cen && !ram_nWE) begin
        if (ram_addr !== AW'(wr) ||
            ram_data !== 8'h00) bad++;
        wr++;
      end
      if (clr_done) begin
        dn++;
        done_at = wr;
      end
    end
    clr_start = 1'b0;
    check("fill_writes", wr, 2048);
    check("fill_seq_errs", bad, 0);
    check("fill_done_count", dn, 1);
    check("fill_done_at_last", done_at, 2048);
    check("fill_busy_end", clr_busy, 0);
    nz = 0;
    for (int i = 0; i < N; i++)
      if (mem[i] !== 8'h00) nz++;
    check("fill_ram_zero", nz, 0);

    // Fill with random CPU / video traffic
    do_preload();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    d0 = done_cnt;
    repeat (300) tick();
    for (int i = 0; i < N; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 24; i++) begin
      cpu_ops.push_back(mk(
        1'($urandom_range(0, 1)),
        AW'(128 + $urandom_range(0, 127)),
        8'($urandom_range(0, 255))));
      vid_ops.push_back(mk(1'b0,
        AW'($urandom_range(0, 127)), 8'h00));
    end
    rand_gap = 1;
    n = 0;
    while ((pending() != 0 || clr_busy) && n < 4000) begin
      tick();
      n++;
    end
    rand_gap = 0;
    check("mix_all_acked", pending(), 0);
    check("mix_fill_done", done_cnt - d0, 1);
    check("mix_busy_end", clr_busy, 0);
    vid_ops.push_back(mk(1'b0, 11'h7FF, 8'h00));
    cpu_ops.push_back(mk(1'b0, 11'h400, 8'h00));
    drain("mix_final_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
